// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues word fetches to instruction memory and queues
// instruction/PC pairs for decode. Branch/jump redirects flush everything fetched so far.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W  = CNT_W + 1;
    localparam logic [31:0] PC_MOD = 32'(IMEM_WORDS * 4);

    logic [31:0]      fetch_pc;
    logic [31:0]      inflight_pc;
    logic             inflight;
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             pop;
    logic             push;
    logic             issue;
    logic [OCC_W-1:0] occupancy;
    logic [31:0]      pc_next;

    // Issue when the buffer can absorb every outstanding word after this cycle's pop.
    always_comb begin
        pop       = inst_valid && inst_ready;
        occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
        issue     = !reset && !redirect_valid && (occupancy < OCC_W'(DEPTH));
        push      = inflight && !redirect_valid && !reset;
        pc_next   = (fetch_pc + 32'd4) % PC_MOD;
    end

    assign imem_req   = issue;
    assign imem_addr  = fetch_pc;
    assign inst_valid = (count != '0);
    assign inst_data  = inst_valid ? data_q[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? pc_q[rd_ptr]   : '0;

    // Fetch PC, in-flight tracking and FIFO pointers; a redirect wipes all of it.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= pc_next;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: the head is masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]   <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by random traffic, every cycle
// compared against a queue-based reference of the fetch buffer.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned DEPTH      = 2;
    localparam int unsigned IMEM_WORDS = 64;
    localparam logic [31:0] LIM        = 32'(IMEM_WORDS * 4);

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    instr_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .DEPTH     (DEPTH),
        .IMEM_WORDS(IMEM_WORDS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    bit          m_inflight;
    logic [31:0] m_ipc;
    logic [31:0] m_pc;
    logic [31:0] got[$];
    int          checks;
    int          failures;
    bit          chk_en;
    bit          prev_req;
    logic [31:0] prev_addr;

    function automatic logic [31:0] memw(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0004: return 32'h0198_06B3;
            32'h0000_002C: return 32'h0094_8663;
            default:       return {a[15:0] ^ 16'hC3A5, a[15:0]};
        endcase
    endfunction

    function automatic logic [31:0] got_at(input int i);
        if (i < got.size()) return got[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the reference, then advance it.
    task automatic step(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
        bit e_valid;
        bit e_pop;
        bit e_req;
        @(negedge clk);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        imem_rdata     = prev_req ? memw(prev_addr) : $urandom();
        #1;
        e_valid = (mq.size() != 0);
        e_pop   = e_valid && rdy;
        e_req   = !rst && !rv && ((mq.size() + int'(m_inflight) - int'(e_pop)) < int'(DEPTH));
        if (chk_en) begin
            chk("inst_valid", 32'(inst_valid), 32'(e_valid));
            chk("imem_req", 32'(imem_req), 32'(e_req));
            chk("imem_addr", imem_addr, m_pc);
            if (e_valid) begin
                chk("inst_pc", inst_pc, mq[0].pc);
                chk("inst_data", inst_data, mq[0].data);
            end
        end
        if (inst_valid === 1'b1 && rdy) got.push_back(inst_pc);
        prev_req  = (imem_req === 1'b1);
        prev_addr = imem_addr;
        if (rst) begin
            mq.delete();
            m_inflight = 1'b0;
            m_pc       = RESET_PC;
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (rv) begin
                mq.delete();
                m_inflight = 1'b0;
                m_pc       = {rpc[31:2], 2'b00};
            end else begin
                if (m_inflight) mq.push_back(ent_t'{m_ipc, memw(m_ipc)});
                m_inflight = e_req;
                if (e_req) begin
                    m_ipc = m_pc;
                    m_pc  = (m_pc + 32'd4) % LIM;
                end
            end
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        got.delete();
    endtask

    initial begin
        bit          rst;
        bit          rv;
        bit          rdy;
        int          r;
        logic [31:0] rpc;

        checks         = 0;
        failures       = 0;
        chk_en         = 1'b0;
        prev_req       = 1'b0;
        prev_addr      = '0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        imem_rdata     = '0;
        m_pc           = RESET_PC;
        m_inflight     = 1'b0;
        m_ipc          = '0;

        // Reset state and free-running fetch
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk_en = 1'b1;
        do_reset();
        chk("rst_data", inst_data, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_addr", imem_addr, RESET_PC);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("c1_req", 32'(imem_req), 32'd1);
        chk("c1_addr", imem_addr, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("c3_valid", 32'(inst_valid), 32'd1);
        chk("c3_pc", inst_pc, 32'h0);
        chk("c3_data", inst_data, 32'h0000_0013);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("c4_pc", inst_pc, 32'h4);
        chk("c4_data", inst_data, 32'h0198_06B3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("stream_n", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk("stream_pc", got_at(i), 32'(4 * i));

        // Backpressure after the first valid entry
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            chk("bp_pc", inst_pc, 32'h0);
            chk("bp_data", inst_data, 32'h0000_0013);
        end
        chk("bp_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("bp_n", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk("bp_order", got_at(i), 32'(4 * i));

        // Redirect with pc 4 buffered and pc 8 in flight
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h2C, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rd1_valid", 32'(inst_valid), 32'd0);
        chk("rd1_addr", imem_addr, 32'h2C);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rd2_valid", 32'(inst_valid), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rd3_valid", 32'(inst_valid), 32'd1);
        chk("rd3_pc", inst_pc, 32'h2C);
        chk("rd3_data", inst_data, 32'h0094_8663);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rd_first", got_at(0), 32'h0);
        chk("rd_target", got_at(1), 32'h2C);
        for (int i = 0; i < got.size(); i++)
            chk("rd_stale", 32'(got[i] == 32'h4 || got[i] == 32'h8), 32'd0);

        // Misaligned target
        step(1'b0, 1'b1, 32'h1E, 1'b1);
        got.delete();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("mis_addr", imem_addr, 32'h1C);
        chk("mis_req", 32'(imem_req), 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("mis_pc", got_at(0), 32'h1C);

        // Wrap at the top of instruction memory
        step(1'b0, 1'b1, 32'hFC, 1'b1);
        got.delete();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap0", got_at(0), 32'hFC);
        chk("wrap1", got_at(1), 32'h00);
        chk("wrap2", got_at(2), 32'h04);

        // Back-to-back redirects: the last one wins
        step(1'b0, 1'b1, 32'h40, 1'b1);
        step(1'b0, 1'b1, 32'h80, 1'b1);
        got.delete();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rr_pc", got_at(0), 32'h80);

        // Reset mid-stream with a buffered entry and a fetch in flight
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h44, 1'b0);
        got.delete();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("mr_valid", 32'(inst_valid), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("mr_first", got_at(0), RESET_PC);

        // Random traffic against the reference
        for (int i = 0; i < 800; i++) begin
            r   = int'($urandom_range(0, 99));
            rst = (r < 1);
            rv  = (r >= 1) && (r < 8);
            rpc = 32'($urandom_range(0, 511));
            rdy = ($urandom_range(0, 9) < 7);
            step(rst, rv, rpc, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
